// File: rtl/rx_ctrl_module_if.sv
// Handshake/bus bundle between the UART receive sequencer and its neighbours.
// master: the sequencer side; slave: detector/baud counter/consumer side.
interface rx_ctrl_module_if;
    logic       RX_En_Sig;
    logic       H_L_Sig;
    logic       RX_Pin_In;
    logic       BPS_CLK;
    logic       RX_Ack;
    logic       Count_Sig;
    logic [7:0] RX_Data;
    logic       RX_Valid;
    logic       RX_Done_Sig;
    logic       Frame_Err;
    logic       Overrun_Err;
    logic       Parity_Err;

    modport master (
        input  RX_En_Sig, H_L_Sig, RX_Pin_In, BPS_CLK, RX_Ack,
        output Count_Sig, RX_Data, RX_Valid, RX_Done_Sig, Frame_Err, Overrun_Err, Parity_Err
    );

    modport slave (
        output RX_En_Sig, H_L_Sig, RX_Pin_In, BPS_CLK, RX_Ack,
        input  Count_Sig, RX_Data, RX_Valid, RX_Done_Sig, Frame_Err, Overrun_Err, Parity_Err
    );
endinterface

// File: rtl/rx_ctrl_module.sv
// UART receive sequencer: start detect, LSB-first assembly, valid/ack byte handoff.
// Optional parity stage enabled by defining RX_PARITY_EN.
module rx_ctrl_module #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic             CLK,
    input  logic             RSTn,
    rx_ctrl_module_if.master rx
);

    if (DATA_BITS < 5 || DATA_BITS > 8 || PARITY_ODD > 1) begin : g_cfg_check
        $error("rx_ctrl_module: unsupported DATA_BITS/PARITY_ODD");
    end

    localparam logic [2:0] LastBit = 3'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef RX_PARITY_EN
        StParity,
`endif
        StStop
    } state_e;

    state_e                 state_q, state_d;
    logic [2:0]             cnt_q, cnt_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [7:0]             data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   done_q, done_d;
    logic                   ferr_q, ferr_d;
    logic                   oerr_q, oerr_d;
    logic                   perr_q, perr_d;
    logic                   par_bad_q, par_bad_d;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            ferr_q    <= 1'b0;
            oerr_q    <= 1'b0;
            perr_q    <= 1'b0;
            par_bad_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
            ferr_q    <= ferr_d;
            oerr_q    <= oerr_d;
            perr_q    <= perr_d;
            par_bad_q <= par_bad_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = valid_q;
        done_d    = 1'b0;
        ferr_d    = ferr_q;
        oerr_d    = oerr_q;
        perr_d    = perr_q;
        par_bad_d = par_bad_q;

        // Ack clears first so that an error raised by a frame ending this cycle still sticks.
        if (rx.RX_Ack) begin
            valid_d = 1'b0;
            ferr_d  = 1'b0;
            oerr_d  = 1'b0;
            perr_d  = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (rx.H_L_Sig && rx.RX_En_Sig) begin
                    state_d   = StStart;
                    par_bad_d = 1'b0;
                end
            end
            StStart: begin
                if (rx.BPS_CLK) begin
                    if (rx.RX_Pin_In) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                        ferr_d  = 1'b1;
                    end else begin
                        state_d = StData;
                        cnt_d   = '0;
                    end
                end
            end
            StData: begin
                if (rx.BPS_CLK) begin
                    shift_d = {rx.RX_Pin_In, shift_q[DATA_BITS-1:1]};
                    cnt_d   = cnt_q + 3'd1;
                    if (cnt_q == LastBit) begin
`ifdef RX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end
                end
            end
`ifdef RX_PARITY_EN
            StParity: begin
                if (rx.BPS_CLK) begin
                    par_bad_d = rx.RX_Pin_In ^ (^shift_q) ^ (PARITY_ODD != 0);
                    state_d   = StStop;
                end
            end
`endif
            StStop: begin
                if (rx.BPS_CLK) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                    if (!rx.RX_Pin_In || par_bad_q) begin
                        if (!rx.RX_Pin_In) ferr_d = 1'b1;
                        if (par_bad_q)     perr_d = 1'b1;
                    end else if (valid_q && !rx.RX_Ack) begin
                        oerr_d = 1'b1;
                    end else begin
                        data_d  = 8'(shift_q);
                        valid_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign rx.Count_Sig   = (state_q != StIdle);
    assign rx.RX_Data     = data_q;
    assign rx.RX_Valid    = valid_q;
    assign rx.RX_Done_Sig = done_q;
    assign rx.Frame_Err   = ferr_q;
    assign rx.Overrun_Err = oerr_q;
`ifdef RX_PARITY_EN
    assign rx.Parity_Err  = perr_q;
`else
    assign rx.Parity_Err  = 1'b0;
`endif

endmodule

// File: tb/tb_rx_ctrl_module.sv
// Directed bench for rx_ctrl_module: frame table plus hand sequences for glitch,
// enable, parity, ack/completion collision and mid-frame reset.
module tb_rx_ctrl_module;

    localparam int BitClks = 16;
    localparam int Half    = 8;

    logic CLK = 1'b0;
    logic RSTn;
    int   total = 0;
    int   bad   = 0;
    int   done_cnt = 0;

    rx_ctrl_module_if rx ();

    rx_ctrl_module #(.DATA_BITS(8), .PARITY_ODD(0)) dut (
        .CLK  (CLK),
        .RSTn (RSTn),
        .rx   (rx)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) if (rx.RX_Done_Sig === 1'b1) done_cnt++;

    typedef struct {
        bit         ack_first;
        logic [7:0] data;
        bit         stop;
        bit         ack_stop;
        bit         exp_valid;
        logic [7:0] exp_data;
        bit         exp_ferr;
        bit         exp_oerr;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".count"}, 32'(rx.Count_Sig), 0);
        check({tag, ".data"}, 32'(rx.RX_Data), 0);
        check({tag, ".valid"}, 32'(rx.RX_Valid), 0);
        check({tag, ".done"}, 32'(rx.RX_Done_Sig), 0);
        check({tag, ".ferr"}, 32'(rx.Frame_Err), 0);
        check({tag, ".oerr"}, 32'(rx.Overrun_Err), 0);
        check({tag, ".perr"}, 32'(rx.Parity_Err), 0);
    endtask

    task automatic pulse_ack();
        @(negedge CLK);
        rx.RX_Ack = 1'b1;
        @(negedge CLK);
        rx.RX_Ack = 1'b0;
    endtask

    // Plays the line, the edge detector and the baud strobe for one frame.
    task automatic send_frame(input logic [7:0] d, input bit stop, input bit par_bad,
                              input bit ack_stop, input bit drop_en, input int rst_bit);
        logic bits[$];
        logic prev;
        bit   aborted;
        bits.push_back(1'b0);
        for (int k = 0; k < 8; k++) bits.push_back(d[k]);
`ifdef RX_PARITY_EN
        bits.push_back((^d) ^ par_bad);
`else
        if (par_bad) bits.push_back(1'b1);
`endif
        bits.push_back(stop);
        prev    = 1'b1;
        aborted = 1'b0;
        for (int i = 0; i < bits.size() && !aborted; i++) begin
            for (int c = 0; c < BitClks; c++) begin
                @(negedge CLK);
                rx.RX_Pin_In = bits[i];
                rx.H_L_Sig   = (c == 0) && prev && !bits[i];
                rx.BPS_CLK   = (c == Half);
                rx.RX_Ack    = ack_stop && (i == bits.size() - 1) && (c == Half);
                if (drop_en && i == 3 && c == 0) rx.RX_En_Sig = 1'b0;
                if (i == rst_bit && c == 2) begin
                    RSTn = 1'b0;
                    #1;
                    check_zero("rst_mid");
                    aborted = 1'b1;
                    break;
                end
            end
            prev = bits[i];
        end
        @(negedge CLK);
        rx.RX_Pin_In = 1'b1;
        rx.H_L_Sig   = 1'b0;
        rx.BPS_CLK   = 1'b0;
        rx.RX_Ack    = 1'b0;
    endtask

    task automatic check_byte(input string tag, input bit v, input logic [7:0] d,
                              input bit fe, input bit oe, input int dn);
        check({tag, ".valid"}, 32'(rx.RX_Valid), 32'(v));
        check({tag, ".data"}, 32'(rx.RX_Data), 32'(d));
        check({tag, ".ferr"}, 32'(rx.Frame_Err), 32'(fe));
        check({tag, ".oerr"}, 32'(rx.Overrun_Err), 32'(oe));
        check({tag, ".perr"}, 32'(rx.Parity_Err), 0);
        check({tag, ".done"}, 32'(dn), 1);
        check({tag, ".count"}, 32'(rx.Count_Sig), 0);
    endtask

    initial begin
        int d0;

        vecs[0] = '{1'b1, 8'h55, 1'b1, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 8'hA3, 1'b1, 1'b0, 1'b1, 8'hA3, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 8'h3C, 1'b1, 1'b0, 1'b1, 8'hA3, 1'b0, 1'b1};
        vecs[3] = '{1'b0, 8'h5A, 1'b1, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 8'h12, 1'b1, 1'b0, 1'b1, 8'h12, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 8'hC4, 1'b0, 1'b0, 1'b1, 8'h12, 1'b1, 1'b0};
        vecs[7] = '{1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};

        RSTn         = 1'b0;
        rx.RX_En_Sig = 1'b1;
        rx.H_L_Sig   = 1'b0;
        rx.RX_Pin_In = 1'b1;
        rx.BPS_CLK   = 1'b0;
        rx.RX_Ack    = 1'b0;
        repeat (3) @(negedge CLK);
        check_zero("reset");
        RSTn = 1'b1;
        repeat (4) @(negedge CLK);

        for (int r = 0; r < 8; r++) begin
            if (vecs[r].ack_first) pulse_ack();
            d0 = done_cnt;
            send_frame(vecs[r].data, vecs[r].stop, 1'b0, vecs[r].ack_stop, 1'b0, -1);
            check_byte($sformatf("vec%0d", r), vecs[r].exp_valid, vecs[r].exp_data,
                       vecs[r].exp_ferr, vecs[r].exp_oerr, done_cnt - d0);
        end

        // Overrun then ack clears valid and the sticky flag.
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, -1);
        check("ovr.oerr", 32'(rx.Overrun_Err), 1);
        check("ovr.data", 32'(rx.RX_Data), 32'h00);
        pulse_ack();
        check("ack.valid", 32'(rx.RX_Valid), 0);
        check("ack.oerr", 32'(rx.Overrun_Err), 0);

        // Short low glitch: START samples 1.
        d0 = done_cnt;
        for (int c = 0; c < BitClks; c++) begin
            @(negedge CLK);
            rx.RX_Pin_In = (c < 4) ? 1'b0 : 1'b1;
            rx.H_L_Sig   = (c == 0);
            rx.BPS_CLK   = (c == Half);
        end
        @(negedge CLK);
        rx.H_L_Sig = 1'b0;
        rx.BPS_CLK = 1'b0;
        check("glitch.ferr", 32'(rx.Frame_Err), 1);
        check("glitch.count", 32'(rx.Count_Sig), 0);
        check("glitch.done", 32'(done_cnt - d0), 1);
        check("glitch.valid", 32'(rx.RX_Valid), 0);
        pulse_ack();
        d0 = done_cnt;
        send_frame(8'h12, 1'b1, 1'b0, 1'b0, 1'b0, -1);
        check_byte("after_glitch", 1'b1, 8'h12, 1'b0, 1'b0, done_cnt - d0);

        // Receive disabled: starts ignored.
        pulse_ack();
        rx.RX_En_Sig = 1'b0;
        d0 = done_cnt;
        send_frame(8'h66, 1'b1, 1'b0, 1'b0, 1'b0, -1);
        check("dis.done", 32'(done_cnt - d0), 0);
        check("dis.valid", 32'(rx.RX_Valid), 0);
        check("dis.data", 32'(rx.RX_Data), 32'h12);

        // Enable dropped mid-frame: frame still completes.
        rx.RX_En_Sig = 1'b1;
        d0 = done_cnt;
        send_frame(8'h96, 1'b1, 1'b0, 1'b0, 1'b1, -1);
        check_byte("en_drop", 1'b1, 8'h96, 1'b0, 1'b0, done_cnt - d0);
        rx.RX_En_Sig = 1'b1;

`ifdef RX_PARITY_EN
        pulse_ack();
        send_frame(8'h07, 1'b1, 1'b1, 1'b0, 1'b0, -1);
        check("par_bad.perr", 32'(rx.Parity_Err), 1);
        check("par_bad.valid", 32'(rx.RX_Valid), 0);
        pulse_ack();
        send_frame(8'h07, 1'b1, 1'b0, 1'b0, 1'b0, -1);
        check("par_ok.perr", 32'(rx.Parity_Err), 0);
        check("par_ok.valid", 32'(rx.RX_Valid), 1);
        check("par_ok.data", 32'(rx.RX_Data), 32'h07);
`endif

        // Reset during data bit 4 of 0x81, then resend.
        send_frame(8'h81, 1'b1, 1'b0, 1'b0, 1'b0, 5);
        RSTn = 1'b1;
        repeat (BitClks) @(negedge CLK);
        check_zero("post_rst");
        d0 = done_cnt;
        send_frame(8'h81, 1'b1, 1'b0, 1'b0, 1'b0, -1);
        check_byte("resend", 1'b1, 8'h81, 1'b0, 1'b0, done_cnt - d0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
